code_entry: RTL and testbench

- Keypad-side front end of the six-digit lock: collects decoded key presses into a six-digit entry buffer and drives the compare-strobe / entered-digit bus (s, a1..a6) of the downstream comparator.
- Supports digit entry, backspace, clear, confirm and an idle timeout.
- Issues exactly one compare strobe per valid six-digit attempt, then clears the buffer.

---
 rtl/code_entry.sv | 121 ++++++++++++
 tb/tb_code_entry.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/code_entry.sv
// Keypad entry front end for the six-digit lock: buffers up to six digits,
// handles clear/backspace/confirm and an idle timeout, and strobes the comparator.
module code_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       s,
    output logic [3:0] a1,
    output logic [3:0] a2,
    output logic [3:0] a3,
    output logic [3:0] a4,
    output logic [3:0] a5,
    output logic [3:0] a6,
    output logic [2:0] digit_cnt,
    output logic       entry_err,
    output logic       timeout
);

    localparam logic [3:0] KEY_CLEAR   = 4'hA;
    localparam logic [3:0] KEY_BACK    = 4'hB;
    localparam logic [3:0] KEY_CONFIRM = 4'hC;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    // FLUSH is folded into the CHECK exit edge, so keys are taken again
    // two cycles after confirm.
    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        CHECK = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_reg;
    logic [3:0]    a_reg [0:5];
    logic [2:0]    cnt_reg;
    logic [TW-1:0] timer_reg;
    logic          s_reg;
    logic          entry_err_reg;
    logic          timeout_reg;

    logic key_accept;
    assign key_accept = key_valid && en && (key_code <= KEY_CONFIRM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ENTRY;
            cnt_reg       <= 3'd0;
            timer_reg     <= '0;
            s_reg         <= 1'b0;
            entry_err_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            for (int i = 0; i < 6; i++) a_reg[i] <= 4'd0;
        end else begin
            s_reg         <= 1'b0;
            entry_err_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            case (state_reg)
                CHECK, FLUSH: begin
                    state_reg <= ENTRY;
                    cnt_reg   <= 3'd0;
                    timer_reg <= '0;
                    for (int i = 0; i < 6; i++) a_reg[i] <= 4'd0;
                end
                default: begin
                    if (key_accept) begin
                        timer_reg <= '0;
                        if (key_code <= 4'h9) begin
                            if (cnt_reg < 3'd6) begin
                                a_reg[cnt_reg] <= key_code;
                                cnt_reg        <= cnt_reg + 3'd1;
                            end
                        end else if (key_code == KEY_BACK) begin
                            if (cnt_reg != 3'd0) begin
                                a_reg[cnt_reg - 3'd1] <= 4'd0;
                                cnt_reg               <= cnt_reg - 3'd1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            cnt_reg <= 3'd0;
                            for (int i = 0; i < 6; i++) a_reg[i] <= 4'd0;
                        end else begin
                            if (cnt_reg == 3'd6) begin
                                state_reg <= CHECK;
                                s_reg     <= 1'b1;
                            end else begin
                                entry_err_reg <= 1'b1;
                                cnt_reg       <= 3'd0;
                                for (int i = 0; i < 6; i++) a_reg[i] <= 4'd0;
                            end
                        end
                    end else if (cnt_reg == 3'd0) begin
                        timer_reg <= '0;
                    end else if (timer_reg == TIMER_LAST) begin
                        // Idle too long: drop the partial entry.
                        timer_reg   <= '0;
                        timeout_reg <= 1'b1;
                        cnt_reg     <= 3'd0;
                        for (int i = 0; i < 6; i++) a_reg[i] <= 4'd0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign s         = s_reg;
    assign a1        = a_reg[0];
    assign a2        = a_reg[1];
    assign a3        = a_reg[2];
    assign a4        = a_reg[3];
    assign a5        = a_reg[4];
    assign a6        = a_reg[5];
    assign digit_cnt = cnt_reg;
    assign entry_err = entry_err_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry with a short idle timeout.
module tb_code_entry;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       s;
    logic [3:0] a1, a2, a3, a4, a5, a6;
    logic [2:0] digit_cnt;
    logic       entry_err;
    logic       timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    code_entry #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .key_valid(key_valid), .key_code(key_code),
        .s(s), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6),
        .digit_cnt(digit_cnt), .entry_err(entry_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    logic [23:0] buf_w;
    assign buf_w = {a1, a2, a3, a4, a5, a6};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
        $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp_v);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Key held across exactly one rising edge; returns at the following negedge.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp_v);
        chk(tag, {29'd0, s, entry_err, timeout}, {29'd0, exp_v});
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_buf", {8'd0, buf_w}, 32'd0);
        chk("reset_cnt", {29'd0, digit_cnt}, 32'd0);
        chk_flags("reset_flags", 3'b000);
        rst_n = 1'b1;
        tick();

        // Full six-digit attempt.
        for (int i = 1; i <= 6; i++) press(4'(i));
        chk("t1_buf", {8'd0, buf_w}, 32'h123456);
        chk("t1_cnt", {29'd0, digit_cnt}, 32'd6);
        press(4'hC);
        chk_flags("t1_strobe", 3'b100);
        chk("t1_buf_in_s", {8'd0, buf_w}, 32'h123456);
        tick();
        chk_flags("t1_after_s", 3'b000);
        chk("t1_flushed", {8'd0, buf_w}, 32'd0);
        chk("t1_cnt0", {29'd0, digit_cnt}, 32'd0);

        // Backspace then short confirm.
        press(4'h7); chk("t2_cnt_a", {29'd0, digit_cnt}, 32'd1);
        press(4'h8); chk("t2_cnt_b", {29'd0, digit_cnt}, 32'd2);
        press(4'hB); chk("t2_cnt_c", {29'd0, digit_cnt}, 32'd1);
        press(4'h9); chk("t2_cnt_d", {29'd0, digit_cnt}, 32'd2);
        chk("t2_buf", {8'd0, buf_w}, 32'h790000);
        press(4'hC);
        chk_flags("t2_err", 3'b010);
        chk("t2_cleared", {8'd0, buf_w}, 32'd0);
        chk("t2_cnt0", {29'd0, digit_cnt}, 32'd0);
        tick();
        chk_flags("t2_err_gone", 3'b000);

        // Seventh digit ignored; key during strobe dropped.
        for (int i = 0; i <= 6; i++) press(4'(i));
        chk("t3_buf", {8'd0, buf_w}, 32'h012345);
        chk("t3_cnt", {29'd0, digit_cnt}, 32'd6);
        press(4'hC);
        chk_flags("t3_strobe", 3'b100);
        press(4'h9);
        chk_flags("t3_after_s", 3'b000);
        chk("t3_dropped_cnt", {29'd0, digit_cnt}, 32'd0);
        chk("t3_dropped_buf", {8'd0, buf_w}, 32'd0);

        // Idle timeout 20 edges after the accepting edge.
        press(4'h3);
        chk("t4_cnt1", {29'd0, digit_cnt}, 32'd1);
        repeat (TO - 1) tick();
        chk_flags("t4_before_expiry", 3'b000);
        chk("t4_cnt_held", {29'd0, digit_cnt}, 32'd1);
        tick();
        chk_flags("t4_timeout", 3'b001);
        chk("t4_cnt_zero", {29'd0, digit_cnt}, 32'd0);
        tick();
        chk_flags("t4_timeout_gone", 3'b000);
        // Key on the expiry edge wins.
        press(4'h3);
        repeat (TO - 1) tick();
        press(4'h4);
        chk_flags("t4_key_wins", 3'b000);
        chk("t4_cnt2", {29'd0, digit_cnt}, 32'd2);
        chk("t4_buf", {8'd0, buf_w}, 32'h340000);
        tick();
        chk_flags("t4_no_late_timeout", 3'b000);
        press(4'hA);
        chk("t4_clear", {29'd0, digit_cnt}, 32'd0);

        // Enable gating.
        press(4'h1); press(4'h2); press(4'h3);
        en = 1'b0;
        press(4'h5);
        press(4'hC);
        chk("t5_cnt_held", {29'd0, digit_cnt}, 32'd3);
        chk("t5_buf_held", {8'd0, buf_w}, 32'h123000);
        chk_flags("t5_no_flags", 3'b000);
        en = 1'b1;
        press(4'h4); press(4'h5); press(4'h6);
        press(4'hC);
        chk_flags("t5_strobe", 3'b100);
        chk("t5_buf", {8'd0, buf_w}, 32'h123456);
        tick();

        // Asynchronous reset during the strobe cycle.
        for (int i = 1; i <= 6; i++) press(4'(i));
        press(4'hC);
        chk_flags("t6_strobe", 3'b100);
        #2 rst_n = 1'b0;
        #1;
        chk_flags("t6_async_flags", 3'b000);
        chk("t6_async_buf", {8'd0, buf_w}, 32'd0);
        chk("t6_async_cnt", {29'd0, digit_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        press(4'h8);
        chk("t6_recover_cnt", {29'd0, digit_cnt}, 32'd1);
        chk("t6_recover_buf", {8'd0, buf_w}, 32'h800000);
        chk_flags("t6_recover_flags", 3'b000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
